vliw_alu_arbiter: RTL and testbench

//  Shares the single 8-bit ALU between the two issue slots of a VLIW bundle. When

---
 rtl/vliw_pkg.sv | 15 +
 rtl/vliw_alu_arbiter.sv | 138 +++++++++++++
 tb/tb_vliw_alu_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW ALU arbiter: FSM state encoding, ALU idle opcode
// and default datapath widths.
package vliw_pkg;

  localparam int DW_DEF  = 8;
  localparam int OPW_DEF = 4;

  localparam logic [OPW_DEF-1:0] ALU_NOP = '0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vliw_alu_arbiter.sv
// Shares one ALU between two VLIW issue slots, serializing dual requests with a one-cycle stall.
// Optional stall-cycle counter enabled by defining ARB_STALL_CNT_EN.
module vliw_alu_arbiter
  import vliw_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int OPW  = OPW_DEF,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            bundle_valid,
  input  logic            s0_req,
  input  logic            s1_req,
  input  logic [OPW-1:0]  s0_op,
  input  logic [OPW-1:0]  s1_op,
  input  logic [DW-1:0]   s0_a,
  input  logic [DW-1:0]   s0_b,
  input  logic [DW-1:0]   s1_a,
  input  logic [DW-1:0]   s1_b,
  output logic [OPW-1:0]  alu_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_result,
  output logic            stall,
  output logic [DW-1:0]   s0_result,
  output logic [DW-1:0]   s1_result,
  output logic            s0_wen,
  output logic            s1_wen,
  output logic [CNTW-1:0] stall_cnt
);

  arb_state_e    state_q, state_d;
  logic          grant0, grant1;
  logic [DW-1:0] s0_result_q, s0_result_d;
  logic [DW-1:0] s1_result_q, s1_result_d;
  logic          s0_wen_q, s0_wen_d;
  logic          s1_wen_q, s1_wen_d;

  // Grants are suppressed while RESET is held so the ALU sees NOP and stall stays low.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    stall   = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_IDLE: begin
          if (bundle_valid) begin
            if (s0_req && s1_req) begin
              grant0  = 1'b1;
              stall   = 1'b1;
              state_d = ST_SECOND;
            end else if (s0_req) begin
              grant0 = 1'b1;
            end else if (s1_req) begin
              grant1 = 1'b1;
            end
          end
        end
        ST_SECOND: begin
          // Dropping bundle_valid here is a flush: slot1 is abandoned.
          state_d = ST_IDLE;
          grant1  = bundle_valid;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op = OPW'(ALU_NOP);
    alu_a  = '0;
    alu_b  = '0;
    if (grant0) begin
      alu_op = s0_op;
      alu_a  = s0_a;
      alu_b  = s0_b;
    end else if (grant1) begin
      alu_op = s1_op;
      alu_a  = s1_a;
      alu_b  = s1_b;
    end
  end

  always_comb begin
    s0_result_d = grant0 ? alu_result : s0_result_q;
    s1_result_d = grant1 ? alu_result : s1_result_q;
    s0_wen_d    = grant0;
    s1_wen_d    = grant1;
  end

  // Grant cycle -> registered result/wen stage
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      s0_result_q <= '0;
      s1_result_q <= '0;
      s0_wen_q    <= 1'b0;
      s1_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s0_result_q <= s0_result_d;
      s1_result_q <= s1_result_d;
      s0_wen_q    <= s0_wen_d;
      s1_wen_q    <= s1_wen_d;
    end
  end

  assign s0_result = s0_result_q;
  assign s1_result = s1_result_q;
  assign s0_wen    = s0_wen_q;
  assign s1_wen    = s1_wen_q;

`ifdef ARB_STALL_CNT_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vliw_alu_arbiter.sv
// Directed bench for vliw_alu_arbiter with a behavioural ADD/SUB ALU model on alu_result.
module tb_vliw_alu_arbiter;
  import vliw_pkg::*;

  localparam int DW   = 8;
  localparam int OPW  = 4;
  localparam int CNTW = 16;
  localparam logic [OPW-1:0] OP_ADD = 4'd1;
  localparam logic [OPW-1:0] OP_SUB = 4'd2;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            bundle_valid;
  logic            s0_req, s1_req;
  logic [OPW-1:0]  s0_op, s1_op;
  logic [DW-1:0]   s0_a, s0_b, s1_a, s1_b;
  logic [OPW-1:0]  alu_op;
  logic [DW-1:0]   alu_a, alu_b, alu_result;
  logic            stall;
  logic [DW-1:0]   s0_result, s1_result;
  logic            s0_wen, s1_wen;
  logic [CNTW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  vliw_alu_arbiter #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RESET(RESET), .bundle_valid(bundle_valid),
    .s0_req(s0_req), .s1_req(s1_req), .s0_op(s0_op), .s1_op(s1_op),
    .s0_a(s0_a), .s0_b(s0_b), .s1_a(s1_a), .s1_b(s1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .stall(stall), .s0_result(s0_result), .s1_result(s1_result),
    .s0_wen(s0_wen), .s1_wen(s1_wen), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic bv, input logic r0, input logic r1,
                       input logic [OPW-1:0] o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [OPW-1:0] o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    bundle_valid = bv; s0_req = r0; s1_req = r1;
    s0_op = o0; s0_a = a0; s0_b = b0;
    s1_op = o1; s1_a = a1; s1_b = b1;
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef ARB_STALL_CNT_EN
    chk(tag, 32'(stall_cnt), exp_cnt);
`else
    chk(tag, 32'(stall_cnt), 0);
`endif
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    chk("rst_s0_result", 32'(s0_result), 0);
    chk("rst_s1_result", 32'(s1_result), 0);
    chk("rst_s0_wen", 32'(s0_wen), 0);
    chk("rst_s1_wen", 32'(s1_wen), 0);
    chk("rst_stall", 32'(stall), 0);
    chk_cnt("rst_cnt");
    RESET = 1'b0;

    // Idle: requests without bundle_valid are ignored
    drive(1'b0, 1'b1, 1'b1, OP_ADD, 8'd3, 8'd4, OP_SUB, 8'd9, 8'd2);
    chk("idle_op", 32'(alu_op), 32'(ALU_NOP));
    chk("idle_a", 32'(alu_a), 0);
    chk("idle_b", 32'(alu_b), 0);
    chk("idle_stall", 32'(stall), 0);
    tick();
    chk("idle_s0_wen", 32'(s0_wen), 0);
    chk("idle_s1_wen", 32'(s1_wen), 0);

    // Single slot0 request: 3+4
    drive(1'b1, 1'b1, 1'b0, OP_ADD, 8'd3, 8'd4, OP_SUB, 8'd0, 8'd0);
    chk("s0only_stall", 32'(stall), 0);
    chk("s0only_op", 32'(alu_op), 32'(OP_ADD));
    chk("s0only_a", 32'(alu_a), 3);
    tick();
    chk("s0only_result", 32'(s0_result), 7);
    chk("s0only_wen", 32'(s0_wen), 1);
    chk("s0only_s1_wen", 32'(s1_wen), 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    tick();
    chk("s0only_wen_drop", 32'(s0_wen), 0);
    chk("s0only_hold", 32'(s0_result), 7);

    // Single slot1 request: 20-5
    drive(1'b1, 1'b0, 1'b1, OP_ADD, 8'd1, 8'd1, OP_SUB, 8'd20, 8'd5);
    chk("s1only_stall", 32'(stall), 0);
    chk("s1only_b", 32'(alu_b), 5);
    tick();
    chk("s1only_result", 32'(s1_result), 15);
    chk("s1only_wen", 32'(s1_wen), 1);
    chk("s1only_s0_wen", 32'(s0_wen), 0);
    chk("s1only_s0_hold", 32'(s0_result), 7);

    // Dual: slot0 5+6, slot1 9-2
    drive(1'b1, 1'b1, 1'b1, OP_ADD, 8'd5, 8'd6, OP_SUB, 8'd9, 8'd2);
    chk("dual_c0_stall", 32'(stall), 1);
    chk("dual_c0_a", 32'(alu_a), 5);
    exp_cnt++;
    tick();
    chk("dual_c1_stall", 32'(stall), 0);
    chk("dual_c1_a", 32'(alu_a), 9);
    chk("dual_c1_op", 32'(alu_op), 32'(OP_SUB));
    chk("dual_c1_s0_result", 32'(s0_result), 11);
    chk("dual_c1_s0_wen", 32'(s0_wen), 1);
    chk("dual_c1_s1_wen", 32'(s1_wen), 0);
    tick();
    chk("dual_c2_s1_result", 32'(s1_result), 7);
    chk("dual_c2_s1_wen", 32'(s1_wen), 1);
    chk("dual_c2_s0_wen", 32'(s0_wen), 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    chk_cnt("dual_cnt");

    // Flush: bundle_valid dropped in SECOND
    drive(1'b1, 1'b1, 1'b1, OP_ADD, 8'd1, 8'd1, OP_SUB, 8'd50, 8'd1);
    chk("flush_c0_stall", 32'(stall), 1);
    exp_cnt++;
    tick();
    chk("flush_s0_result", 32'(s0_result), 2);
    drive(1'b0, 1'b1, 1'b1, OP_ADD, 8'd1, 8'd1, OP_SUB, 8'd50, 8'd1);
    chk("flush_op", 32'(alu_op), 32'(ALU_NOP));
    chk("flush_stall", 32'(stall), 0);
    tick();
    chk("flush_s1_wen", 32'(s1_wen), 0);
    chk("flush_s1_hold", 32'(s1_result), 7);

    // Back-to-back dual bundles x3 (first stall also proves flush returned to IDLE)
    drive(1'b1, 1'b1, 1'b1, OP_ADD, 8'd10, 8'd20, OP_SUB, 8'd100, 8'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_stall_%0d", i), 32'(stall), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) exp_cnt++;
      tick();
      chk($sformatf("b2b_s0_wen_%0d", i), 32'(s0_wen), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("b2b_s1_wen_%0d", i), 32'(s1_wen), (i % 2 == 0) ? 0 : 1);
    end
    chk("b2b_s0_result", 32'(s0_result), 30);
    chk("b2b_s1_result", 32'(s1_result), 99);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    chk_cnt("b2b_cnt");

    // Reset asserted while in SECOND
    drive(1'b1, 1'b1, 1'b1, OP_ADD, 8'd2, 8'd2, OP_SUB, 8'd8, 8'd3);
    tick();
    chk("rstmid_pre_s0_wen", 32'(s0_wen), 1);
    RESET = 1'b1;
    #1;
    chk("rstmid_s0_wen", 32'(s0_wen), 0);
    chk("rstmid_s0_result", 32'(s0_result), 0);
    chk("rstmid_stall", 32'(stall), 0);
    chk("rstmid_op", 32'(alu_op), 32'(ALU_NOP));
    chk_cnt_reset();
    tick();
    chk("rstmid_s1_wen", 32'(s1_wen), 0);
    chk("rstmid_s1_result", 32'(s1_result), 0);
    RESET = 1'b0;
    drive(1'b1, 1'b1, 1'b1, OP_ADD, 8'd2, 8'd2, OP_SUB, 8'd8, 8'd3);
    chk("rstmid_idle_stall", 32'(stall), 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic chk_cnt_reset();
    exp_cnt = 0;
    chk_cnt("rstmid_cnt");
  endtask

endmodule
